// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor bank: FSM state encoding
// and the default alphabet size.
package enigma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int ALPHA_SIZE_DEF = 26;

endpackage

// File: rtl/enigma_rotor_bank_if.sv
// Control/status bundle between the keypress front end and the rotor bank.
// Positions use the same packing everywhere: rotor i at [i*POS_W +: POS_W].
interface enigma_rotor_bank_if #(
    parameter int NUM_ROTORS = 3,
    parameter int POS_W      = 5
);

    logic                        step_req;
    logic                        load_en;
    logic [NUM_ROTORS*POS_W-1:0] load_pos;
    logic [NUM_ROTORS*POS_W-1:0] notch_pos;
    logic [NUM_ROTORS*POS_W-1:0] rotor_pos;
    logic                        step_done;
    logic [1:0]                  state_dbg;

    modport master (
        output step_req, load_en, load_pos, notch_pos,
        input  rotor_pos, step_done, state_dbg
    );

    modport slave (
        input  step_req, load_en, load_pos, notch_pos,
        output rotor_pos, step_done, state_dbg
    );

endinterface

// File: rtl/enigma_rotor_bank_rotor_cell.sv
// One rotor: position register with clamped load, wrapping advance and a
// notch-compare output used by the carry logic in the bank.
module rotor_cell #(
    parameter int ALPHA_SIZE = 26,
    parameter int POS_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [POS_W-1:0] load_val,
    input  logic             advance,
    input  logic [POS_W-1:0] notch,
    output logic [POS_W-1:0] pos,
    output logic             at_notch
);

    localparam logic [POS_W-1:0] LAST = POS_W'(ALPHA_SIZE - 1);

    // Out-of-range load values fall back to 0 rather than leaving an illegal position
    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= '0;
        end else if (load_en) begin
            pos <= (load_val > LAST) ? '0 : load_val;
        end else if (advance) begin
            pos <= (pos == LAST) ? '0 : pos + POS_W'(1);
        end
    end

    assign at_notch = (pos == notch);

endmodule

// File: rtl/enigma_rotor_bank.sv
// Enigma rotor bank: step FSM with auto-repeat, notch carry chain and load.
// Define ENIGMA_DOUBLE_STEP_EN to model the middle-rotor double-step anomaly.
module enigma_rotor_bank
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int ALPHA_SIZE = ALPHA_SIZE_DEF,
    parameter int POS_W      = 5,
    parameter int REPEAT_DIV = 50_000_000
) (
    input logic                clk,
    input logic                reset,
    enigma_rotor_bank_if.slave bus
);

    localparam int              CNT_W    = $clog2(REPEAT_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_DIV - 1);

    state_t                      state;
    state_t                      state_next;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_next;
    logic                        step_prev;
    logic                        step_done_q;
    logic                        apply_step;
    logic [NUM_ROTORS-1:0]       at_notch;
    logic [NUM_ROTORS-1:0]       adv;
    logic [NUM_ROTORS*POS_W-1:0] pos_all;
    logic                        unused_last_notch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            step_prev   <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            step_prev   <= bus.step_req;
            step_done_q <= apply_step;
        end
    end

    // Load pre-empts everything; the edge detector keeps sampling so a key
    // held across a load must be released before it can step again
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        apply_step = 1'b0;
        if (bus.load_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.step_req && !step_prev) state_next = STEP;
                end
                STEP: begin
                    apply_step = 1'b1;
                    state_next = bus.step_req ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!bus.step_req)      state_next = IDLE;
                    else if (cnt == CNT_LAST) state_next = STEP;
                    else                    cnt_next = cnt + CNT_W'(1);
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A rotor only carries into its neighbour when it is itself moving off its notch
    always_comb begin
        adv    = '0;
        adv[0] = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++) begin
            adv[i] = adv[i-1] & at_notch[i-1];
`ifdef ENIGMA_DOUBLE_STEP_EN
            if (i < NUM_ROTORS - 1) adv[i] = adv[i] | at_notch[i];
`endif
        end
    end

    for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_rotor
        rotor_cell #(
            .ALPHA_SIZE(ALPHA_SIZE),
            .POS_W     (POS_W)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .load_en (bus.load_en),
            .load_val(bus.load_pos[g*POS_W +: POS_W]),
            .advance (apply_step & adv[g]),
            .notch   (bus.notch_pos[g*POS_W +: POS_W]),
            .pos     (pos_all[g*POS_W +: POS_W]),
            .at_notch(at_notch[g])
        );
    end

    assign unused_last_notch = at_notch[NUM_ROTORS-1];

    assign bus.rotor_pos = pos_all;
    assign bus.step_done = step_done_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_enigma_rotor_bank.sv
// Directed self-checking bench for enigma_rotor_bank (3 rotors, 26 letters,
// notches r0=16 r1=4 r2=21, REPEAT_DIV=4). Honours ENIGMA_DOUBLE_STEP_EN.
module tb_enigma_rotor_bank;

    localparam int NUM_ROTORS = 3;
    localparam int ALPHA_SIZE = 26;
    localparam int POS_W      = 5;
    localparam int REPEAT_DIV = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   pulses;

    enigma_rotor_bank_if #(.NUM_ROTORS(NUM_ROTORS), .POS_W(POS_W)) bus ();

    enigma_rotor_bank #(
        .NUM_ROTORS(NUM_ROTORS),
        .ALPHA_SIZE(ALPHA_SIZE),
        .POS_W     (POS_W),
        .REPEAT_DIV(REPEAT_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] pack(input int r0, input int r1, input int r2);
        return {5'(r2), 5'(r1), 5'(r0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_load(input int r0, input int r1, input int r2);
        bus.load_en  = 1'b1;
        bus.load_pos = pack(r0, r1, r2);
        tick();
        bus.load_en  = 1'b0;
    endtask

    // Single press-and-release; positions are expected one edge after STEP
    task automatic apply_stimulus(input string tag, input logic [14:0] exp_pos);
        bus.step_req = 1'b1;
        tick();
        check_output({tag, "_state_step"}, 32'(bus.state_dbg), 32'd1);
        check_output({tag, "_done_early"}, 32'(bus.step_done), 32'd0);
        bus.step_req = 1'b0;
        tick();
        check_output({tag, "_pos"}, 32'(bus.rotor_pos), 32'(exp_pos));
        check_output({tag, "_done_high"}, 32'(bus.step_done), 32'd1);
        tick();
        check_output({tag, "_done_low"}, 32'(bus.step_done), 32'd0);
        check_output({tag, "_state_idle"}, 32'(bus.state_dbg), 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        pulses        = 0;
        reset         = 1'b1;
        bus.step_req  = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_pos  = '0;
        bus.notch_pos = pack(16, 4, 21);
        tick();
        tick();
        reset = 1'b0;
        check_output("reset_pos", 32'(bus.rotor_pos), 32'd0);
        check_output("reset_state", 32'(bus.state_dbg), 32'd0);
        check_output("reset_done", 32'(bus.step_done), 32'd0);

        // Reset while holding the key in HOLD
        bus.step_req = 1'b1;
        tick();
        tick();
        tick();
        check_output("t1_in_hold", 32'(bus.state_dbg), 32'd2);
        check_output("t1_pos_before", 32'(bus.rotor_pos), 32'(pack(1, 0, 0)));
        reset = 1'b1;
        tick();
        check_output("t1_pos", 32'(bus.rotor_pos), 32'd0);
        check_output("t1_state", 32'(bus.state_dbg), 32'd0);
        check_output("t1_done", 32'(bus.step_done), 32'd0);
        reset        = 1'b0;
        bus.step_req = 1'b0;
        tick();

        apply_load(16, 0, 0);
        check_output("t2_load", 32'(bus.rotor_pos), 32'(pack(16, 0, 0)));
        apply_stimulus("t2", pack(17, 1, 0));

        apply_load(25, 7, 2);
        apply_stimulus("t3", pack(0, 7, 2));

        apply_load(3, 4, 0);
`ifdef ENIGMA_DOUBLE_STEP_EN
        apply_stimulus("t4", pack(4, 5, 1));
`else
        apply_stimulus("t4", pack(4, 4, 0));
`endif

        apply_load(30, 26, 9);
        check_output("t5_clamp", 32'(bus.rotor_pos), 32'(pack(0, 0, 9)));
        bus.load_en  = 1'b1;
        bus.load_pos = pack(1, 2, 3);
        bus.step_req = 1'b1;
        tick();
        bus.load_en = 1'b0;
        check_output("t5_load_wins_pos", 32'(bus.rotor_pos), 32'(pack(1, 2, 3)));
        check_output("t5_load_wins_state", 32'(bus.state_dbg), 32'd0);
        tick();
        check_output("t5_held_state", 32'(bus.state_dbg), 32'd0);
        check_output("t5_held_done", 32'(bus.step_done), 32'd0);
        tick();
        check_output("t5_held_pos", 32'(bus.rotor_pos), 32'(pack(1, 2, 3)));
        bus.step_req = 1'b0;
        tick();

        // Auto-repeat: steps land on edges 1, 6 and 11 of a 12-edge hold
        apply_load(0, 0, 0);
        bus.step_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            pulses += int'(bus.step_done);
            if (i == 5) check_output("t6_repeat_step", 32'(bus.state_dbg), 32'd1);
        end
        check_output("t6_pos", 32'(bus.rotor_pos), 32'(pack(3, 0, 0)));
        check_output("t6_pulses", 32'(pulses), 32'd3);
        bus.step_req = 1'b0;
        tick();
        check_output("t6_release", 32'(bus.state_dbg), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
